// File: rtl/otp_decryptor_if.sv
// Valid/ready word stream used for the key, ciphertext and plaintext ports.
interface otp_decryptor_if #(
  parameter int DATA_W = 8
);
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;

  modport master (
    output valid,
    output data,
    input  ready
  );

  modport slave (
    input  valid,
    input  data,
    output ready
  );
endinterface

// File: rtl/otp_decryptor.sv
// One-time-pad decryptor: ciphertext XOR next unused word of a circular pad.
// OTP_ZEROIZE_EN: wipe each pad slot as it is consumed and the whole pad on reset.
module otp_decryptor #(
  parameter  int DATA_W    = 8,
  parameter  int KEY_DEPTH = 16,
  localparam int PW        = $clog2(KEY_DEPTH),
  localparam int CW        = $clog2(KEY_DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  otp_decryptor_if.slave         key_if,
  otp_decryptor_if.slave         ct_if,
  otp_decryptor_if.master        pt_if,
  output logic [CW-1:0]          key_count,
  output logic                   starved
);

  typedef enum logic [1:0] {
    EMPTY,
    PARTIAL,
    FULL
  } occ_e;

  occ_e              occ_q, occ_d;
  logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              pt_valid_q, pt_valid_d;
  logic [DATA_W-1:0] pt_data_q, pt_data_d;
  logic              starved_q;
  logic [DATA_W-1:0] key_q [KEY_DEPTH];

  logic wr_en;
  logic fire;

  assign key_if.ready = (occ_q != FULL);
  assign ct_if.ready  = (occ_q != EMPTY) &&
                        (!pt_valid_q || pt_if.ready);

  assign wr_en = key_if.valid && key_if.ready;
  assign fire  = ct_if.valid && ct_if.ready;

  always_comb begin
    cnt_d = cnt_q;
    unique case (1'b1)
      (wr_en && !fire): cnt_d = cnt_q + CW'(1);
      (fire && !wr_en): cnt_d = cnt_q - CW'(1);
      default: ;
    endcase
  end

  always_comb begin
    occ_d = PARTIAL;
    unique case (1'b1)
      (cnt_d == '0):             occ_d = EMPTY;
      (cnt_d == CW'(KEY_DEPTH)): occ_d = FULL;
      default: ;
    endcase
  end

  // A fire while draining reloads the register, keeping full throughput.
  always_comb begin
    pt_valid_d = pt_valid_q;
    pt_data_d  = pt_data_q;
    if (fire) begin
      pt_valid_d = 1'b1;
      pt_data_d  = ct_if.data ^ key_q[rd_ptr_q];
    end else if (pt_if.ready) begin
      pt_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      occ_q      <= EMPTY;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      pt_valid_q <= 1'b0;
      pt_data_q  <= '0;
      starved_q  <= 1'b0;
    end else begin
      occ_q      <= occ_d;
      cnt_q      <= cnt_d;
      pt_valid_q <= pt_valid_d;
      pt_data_q  <= pt_data_d;
      if (wr_en) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (fire)  rd_ptr_q <= rd_ptr_q + PW'(1);
      if (ct_if.valid && cnt_q == '0) starved_q <= 1'b1;
    end
  end

`ifdef OTP_ZEROIZE_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < KEY_DEPTH; i++) key_q[i] <= '0;
    end else begin
      if (wr_en) key_q[wr_ptr_q] <= key_if.data;
      if (fire)  key_q[rd_ptr_q] <= '0;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (!reset && wr_en) key_q[wr_ptr_q] <= key_if.data;
  end
`endif

  assign pt_if.valid = pt_valid_q;
  assign pt_if.data  = pt_data_q;
  assign key_count   = cnt_q;
  assign starved     = starved_q;

endmodule

// File: tb/tb_otp_decryptor.sv
// Scoreboard bench for otp_decryptor: pad/plaintext queues model the channel.
module tb_otp_decryptor;
  localparam int DW    = 8;
  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] key_count;
  logic       starved;

  otp_decryptor_if #(.DATA_W(DW)) key_if ();
  otp_decryptor_if #(.DATA_W(DW)) ct_if ();
  otp_decryptor_if #(.DATA_W(DW)) pt_if ();

  otp_decryptor #(.DATA_W(DW), .KEY_DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .key_if    (key_if),
    .ct_if     (ct_if),
    .pt_if     (pt_if),
    .key_count (key_count),
    .starved   (starved)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] pad[$];
  logic [DW-1:0] outq[$];
  logic          m_starved = 1'b0;
  logic          in_rst = 1'b1;
  int            checks = 0;
  int            failures = 0;

  function automatic void chk(string n, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", n, a, e);
    end
  endfunction

  task automatic cycle(input logic kv, input logic [DW-1:0] kd,
                       input logic cv, input logic [DW-1:0] cd,
                       input logic pr);
    logic exp_kr, exp_cr, do_fire;
    logic [DW-1:0] pv;
    int sz0;
    @(negedge clk);
    key_if.valid = kv;
    key_if.data  = kd;
    ct_if.valid  = cv;
    ct_if.data   = cd;
    pt_if.ready  = pr;
    #1;
    sz0    = pad.size();
    exp_kr = sz0 < DEPTH;
    exp_cr = sz0 != 0 && (outq.size() == 0 || pr);
    chk("key_ready", 32'(key_if.ready), 32'(exp_kr));
    chk("ct_ready", 32'(ct_if.ready), 32'(exp_cr));
    chk("key_count", 32'(key_count), 32'(sz0));
    chk("starved", 32'(starved), 32'(m_starved));
    do_fire = cv && exp_cr;
    pv = '0;
    if (do_fire) pv = cd ^ pad.pop_front();
    if (kv && exp_kr) pad.push_back(kd);
    if (cv && sz0 == 0) m_starved = 1'b1;
    @(posedge clk);
    if (do_fire) outq.push_back(pv);
  endtask

  task automatic do_reset();
    @(negedge clk);
    in_rst       = 1'b1;
    reset        = 1'b1;
    key_if.valid = 1'b0;
    ct_if.valid  = 1'b0;
    pt_if.ready  = 1'b0;
    @(posedge clk);
    pad.delete();
    outq.delete();
    m_starved = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_pt_valid", 32'(pt_if.valid), 32'd0);
    chk("rst_pt_data", 32'(pt_if.data), 32'd0);
    in_rst = 1'b0;
  endtask

  // Monitor: compare the held plaintext against the scoreboard head.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!in_rst) begin
        chk("pt_valid", 32'(pt_if.valid), 32'(outq.size() != 0));
        if (pt_if.valid && outq.size() != 0) begin
          chk("pt_data", 32'(pt_if.data), 32'(outq[0]));
          if (pt_if.ready) void'(outq.pop_front());
        end
      end
    end
  end

  initial begin
    key_if.valid = 1'b0;
    key_if.data  = '0;
    ct_if.valid  = 1'b0;
    ct_if.data   = '0;
    pt_if.ready  = 1'b0;
    do_reset();

    cycle(1, 8'hA5, 0, 8'h00, 1);
    cycle(1, 8'h3C, 0, 8'h00, 1);
    cycle(1, 8'hFF, 0, 8'h00, 1);
    cycle(0, 8'h00, 1, 8'h00, 1);
    cycle(0, 8'h00, 1, 8'h3C, 1);
    cycle(0, 8'h00, 1, 8'h0F, 1);
    cycle(0, 8'h00, 0, 8'h00, 1);
`ifdef OTP_ZEROIZE_EN
    chk("zeroize_slot0", 32'(dut.key_q[0]), 32'h00);
`else
    chk("keep_slot0", 32'(dut.key_q[0]), 32'hA5);
`endif

    cycle(0, 8'h00, 1, 8'h11, 1);
    cycle(1, 8'h77, 1, 8'h22, 1);
    cycle(0, 8'h00, 1, 8'h33, 1);
    cycle(0, 8'h00, 1, 8'h44, 1);
    cycle(0, 8'h00, 0, 8'h00, 1);

    cycle(1, 8'h10, 0, 8'h00, 1);
    cycle(1, 8'h20, 0, 8'h00, 1);
    cycle(0, 8'h00, 1, 8'h01, 0);
    for (int i = 0; i < 4; i++) cycle(0, 8'h00, 1, 8'h02, 0);
    cycle(0, 8'h00, 1, 8'h02, 1);
    cycle(0, 8'h00, 0, 8'h00, 1);

    do_reset();
    for (int i = 0; i < 17; i++) cycle(1, 8'(i * 7 + 1), 0, 8'h00, 1);
    for (int i = 0; i < 16; i++) cycle(0, 8'h00, 1, 8'(i), 1);
    cycle(1, 8'h5A, 0, 8'h00, 1);
    cycle(0, 8'h00, 1, 8'h5A, 1);
    cycle(0, 8'h00, 0, 8'h00, 1);

    cycle(1, 8'h99, 0, 8'h00, 1);
    cycle(1, 8'h88, 1, 8'h12, 1);
    cycle(1, 8'h66, 1, 8'h34, 0);
    cycle(0, 8'h00, 0, 8'h00, 0);
    do_reset();
    cycle(0, 8'h00, 1, 8'h55, 1);

    for (int i = 0; i < 800; i++) begin
      cycle(1'($urandom_range(0, 2) != 0), 8'($urandom),
            1'($urandom_range(0, 2) != 0), 8'($urandom),
            1'($urandom_range(0, 3) != 0));
      if (i == 400) do_reset();
    end
    for (int i = 0; i < 3; i++) cycle(0, 8'h00, 0, 8'h00, 1);
    chk("drained", 32'(outq.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/otp_decryptor.md
# otp_decryptor

Receiving end of the one-time-pad channel: takes ciphertext words and XORs each with the next unused word of a locally loaded pad, producing plaintext. Pad words arrive through a key-load port into an internal circular key buffer. Each pad word is consumed exactly once and never reused. The block sits between the link receiver (ciphertext source) and the consumer of recovered data, mirroring the encrypting end of the same channel.

## Interface
- DATA_W, 8, width of ciphertext, key and plaintext words
- KEY_DEPTH, 16, pad buffer depth in words (power of two, ≥2)
- clk  in  1  single clock, all state updates on rising edge
- reset  in  1  synchronous, active-high; clears all state on the clock edge where it is high
- key_valid  in  1  pad word offered
- key_data  in  DATA_W  pad word
- key_ready  out  1  high when buffer not full
- ct_valid  in  1  ciphertext word offered
- ct_data  in  DATA_W  ciphertext word
- ct_ready  out  1  ciphertext accepted this cycle if ct_valid also high
- pt_valid  out  1  plaintext word held in output register
- pt_data  out  DATA_W  plaintext word
- pt_ready  in  1  downstream accepts plaintext
- key_count  out  $clog2(KEY_DEPTH+1)  unused pad words stored
- starved  out  1  sticky: ciphertext offered while pad empty

## Operation
- Key buffer: circular, write pointer wr_ptr and read pointer rd_ptr of width $clog2(KEY_DEPTH), wrap KEY_DEPTH-1 → 0; occupancy key_count 0..KEY_DEPTH.
- Key write: key_valid && key_ready stores key_data at wr_ptr, wr_ptr+1.
- ct_ready = (key_count != 0) && (!pt_valid || pt_ready). Purely combinational from registered state plus pt_ready.
- Decrypt fire (ct_valid && ct_ready): pt_data <= ct_data ^ key[rd_ptr]; pt_valid <= 1; rd_ptr+1.
- Output register: pt_valid stays high and pt_data stable until pt_ready is high; pt_valid && pt_ready && no fire → pt_valid <= 0. Fire while draining → new word loaded, pt_valid stays 1 (full throughput).
- key_count: +1 on write only, −1 on fire only, unchanged on both.
- Write and fire in same cycle with key_count==0: fire impossible (ct_ready low); written word usable next cycle. No bypass.
- Write when full: blocked by key_ready=0; key_valid ignored, no state change.
- starved <= 1 on any cycle with ct_valid && key_count==0; cleared only by reset.
- Occupancy states: EMPTY (count 0: ct_ready=0, key_ready=1), PARTIAL, FULL (count KEY_DEPTH: key_ready=0). Transitions only via the count rules above.

## Timing
- Reset values: pt_valid=0, pt_data=0, key_count=0, starved=0, wr_ptr=rd_ptr=0; key_ready=1, ct_ready=0 after reset. Buffer contents need not be cleared (unless OTP_ZEROIZE_EN).
- Reset mid-operation: in-flight plaintext discarded, all unused pad words lost; outputs return to reset values the cycle after reset edge.
- Latency: ciphertext accepted at edge N → pt_valid high after edge N.
- Throughput: one word per cycle when pad available and pt_ready held high.
- Key-to-use latency: word written at edge N usable by fire at edge N+1.

## Configuration
- OTP_ZEROIZE_EN defined: on each fire, key[rd_ptr] is overwritten with 0 on the same edge; on reset all KEY_DEPTH entries are cleared to 0. Write and zeroize never target the same slot in one cycle (guaranteed since slot is occupied).
- Not defined: consumed entries retain old values until overwritten by a new key write; reset does not touch buffer contents.

## Test plan
- Reset then load 0xA5, 0x3C, 0xFF; send ct 0x00, 0x3C, 0x0F with pt_ready=1 → pt 0xA5, 0x00, 0xF0 on consecutive cycles, key_count 3→0.
- Empty pad: ct_valid=1 with key_count=0 → ct_ready=0, starved=1 and stays 1 after a key is loaded and consumed, until reset.
- Backpressure: pt_ready=0 with pt_valid=1 for 4 cycles → pt_data stable, ct_ready=0, key_count unchanged; release → next word accepted same cycle.
- Fill: write 16 keys → key_count=16, key_ready=0; 17th key_valid ignored; consume 16 then reload → pointers wrap, 17th decrypt uses new pad word 0 (e.g. key 0x5A, ct 0x5A → pt 0x00).
- Simultaneous write and fire at key_count=1 → key_count stays 1; reset asserted mid-stream with pt_valid=1 → next cycle pt_valid=0, key_count=0, ct_ready=0.
- With OTP_ZEROIZE_EN: after consuming slot 0 (key 0xA5), hierarchical read of key[0] == 0x00; without macro key[0] == 0xA5.
